// File: rtl/demux_dispatch_ctrl_if.sv
// Upstream word stream and 1-to-8 dispatch bus of demux_dispatch_ctrl.
// The slave modport is the controller's view; the master modport is the view of the
// upstream producer / downstream destinations.
interface demux_dispatch_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_dest;
  logic          mode;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [7:0]    out_ready;
  logic [2:0]    sel;
  logic          busy;
  logic          timeout_err;
  logic [7:0]    drop_cnt;

  modport master (
    output in_valid, in_data, in_dest, mode, out_ready,
    input  in_ready, out_valid, out_data, sel, busy, timeout_err, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_dest, mode, out_ready,
    output in_ready, out_valid, out_data, sel, busy, timeout_err, drop_cnt
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch sequencer in front of a 1-to-8 demux: buffers words in a small FIFO and
// presents each one on a single destination, chosen from the word's own address
// (mode = 0) or from a round-robin pointer (mode = 1).
// Optional feature macro DEMUX_TIMEOUT_EN: when defined, a word that waits TIMEOUT cycles
// on an unresponsive destination is dropped (timeout_err pulse, saturating drop_cnt).
// When undefined, SEND waits forever and timeout_err / drop_cnt are tied to zero.
module demux_dispatch_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rst,
  demux_dispatch_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must lie in 1..255");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e        state_q;
  logic [DW+2:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [2:0]    rr_ptr_q;
  logic          mode_q;
  logic [7:0]    out_valid_q;
  logic [DW-1:0] out_data_q;
  logic [2:0]    sel_q;
  logic [DW+2:0] head;
  logic [2:0]    pop_sel;
  logic          push;
  logic          pop;

  // in_ready depends only on registered count, never on this cycle's pop.
  assign bus.in_ready = ~rst & (count_q != FullCnt);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (state_q == StIdle) & (count_q != '0);
  assign head         = mem_q[rd_ptr_q];
  assign pop_sel      = bus.mode ? rr_ptr_q : head[DW+2:DW];

  // FIFO storage: each entry is {dest, data}.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_dest, bus.in_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef DEMUX_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       timeout_err_q;
  logic [7:0] drop_cnt_q;
`endif

  // Dispatch FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_q       <= '0;
`ifdef DEMUX_TIMEOUT_EN
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
`endif
    end else begin
`ifdef DEMUX_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (pop) begin
            mode_q      <= bus.mode;
            sel_q       <= pop_sel;
            out_valid_q <= 8'b1 << pop_sel;
            out_data_q  <= head[DW-1:0];
            state_q     <= StSend;
`ifdef DEMUX_TIMEOUT_EN
            wait_q      <= '0;
`endif
          end
        end
        StSend: begin
          if (bus.out_ready[sel_q]) begin
            out_valid_q <= '0;
            state_q     <= StIdle;
            if (mode_q) rr_ptr_q <= rr_ptr_q + 3'd1;
          end
`ifdef DEMUX_TIMEOUT_EN
          // Drop on the TIMEOUT-th consecutive stalled SEND cycle.
          else if (wait_q == 8'(TIMEOUT - 1)) begin
            out_valid_q   <= '0;
            state_q       <= StIdle;
            timeout_err_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            if (mode_q) rr_ptr_q <= rr_ptr_q + 3'd1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == StSend) | (count_q != '0);

`ifdef DEMUX_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
  assign bus.drop_cnt    = drop_cnt_q;
`else
  assign bus.timeout_err = 1'b0;
  assign bus.drop_cnt    = 8'h00;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_demux_dispatch_ctrl;
  localparam int unsigned DW      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  demux_dispatch_ctrl_if #(.DW(DW)) bus ();

  demux_dispatch_ctrl #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Transfers observed at the dispatch side, plus per-destination valid-cycle counts.
  logic [7:0] got_data[$];
  logic [2:0] got_dest[$];
  logic [2:0] sent_dest[$];
  int         valid_cycles[8];
  int         err_pulses;
  bit         push_ok;
  bit         wait_ok;

  // Mid-cycle monitor: at most one valid bit, matching sel; records completed transfers.
  always @(negedge clk) begin
    if (!rst && bus.out_valid != 8'h00) begin
      total++;
      if (!$onehot(bus.out_valid) || !bus.out_valid[bus.sel]) begin
        bad++;
        $display("FAIL onehot_sel: out_valid=%b sel=%0d", bus.out_valid, bus.sel);
      end
      valid_cycles[bus.sel]++;
      if (bus.out_ready[bus.sel]) begin
        got_data.push_back(bus.out_data);
        got_dest.push_back(bus.sel);
      end
    end
    if (!rst && bus.timeout_err) err_pulses++;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_data.delete();
    got_dest.delete();
    sent_dest.delete();
    foreach (valid_cycles[k]) valid_cycles[k] = 0;
    err_pulses = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 8'h00;
    cycle();
    cycle();
    rst = 1'b0;
    clear_mon();
  endtask

  // Push n words (data base+i); destination random or fixed. Sets push_ok.
  task automatic push_words(input int n, input logic [7:0] base, input bit rnd,
                            input logic [2:0] fixed);
    push_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [2:0] d;
      bit         acc;
      int         guard;
      d = rnd ? 3'($urandom_range(0, 7)) : fixed;
      bus.in_valid = 1'b1;
      bus.in_data  = base + 8'(i);
      bus.in_dest  = d;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        #1;
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (acc) sent_dest.push_back(d);
      else push_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    wait_ok = 1'b0;
    for (int c = 0; c < budget && got_data.size() < n; c++) cycle();
    if (got_data.size() >= n) wait_ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.in_dest   = 3'd2;
    bus.mode      = 1'b0;
    bus.out_ready = 8'hFF;
    cycle();
    cycle();
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 8'h00) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.sel !== 3'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", bus.sel); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err: got %b want 0", bus.timeout_err); end
    total++; if (bus.drop_cnt !== 8'h00) begin bad++; $display("FAIL rst_drop_cnt: got %0d want 0", bus.drop_cnt); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready: got %b want 1", bus.in_ready); end
    cycle();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_no_push: busy got %b want 0", bus.busy); end
  endtask

  task automatic test_addressed();
    do_reset();
    bus.mode      = 1'b0;
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.in_dest   = 3'd5;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL addr_in_ready: got %b want 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 8'h00 || bus.busy !== 1'b1) begin bad++; $display("FAIL addr_early: out_valid=%b busy=%b want 0/1", bus.out_valid, bus.busy); end
    cycle();
    total++; if (bus.out_valid !== 8'b0010_0000 || bus.sel !== 3'd5 || bus.out_data !== 8'hA5) begin
      bad++; $display("FAIL addr_present: out_valid=%b sel=%0d data=%h want 00100000/5/a5", bus.out_valid, bus.sel, bus.out_data);
    end
    cycle();
    total++; if (bus.out_valid !== 8'h00 || bus.sel !== 3'd5 || bus.out_data !== 8'hA5 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL addr_after: out_valid=%b sel=%0d data=%h busy=%b want 0/5/a5/0", bus.out_valid, bus.sel, bus.out_data, bus.busy);
    end
    // Random addresses, back to back.
    clear_mon();
    push_words(12, 8'h40, 1'b1, 3'd0);
    wait_got(12, 100);
    total++; if (!push_ok || !wait_ok) begin bad++; $display("FAIL addr_stream_done: pushed=%b got=%0d want 12", push_ok, got_data.size()); end
    for (int i = 0; i < got_data.size() && i < sent_dest.size(); i++) begin
      total++;
      if (got_data[i] !== 8'h40 + 8'(i) || got_dest[i] !== sent_dest[i]) begin
        bad++; $display("FAIL addr_stream[%0d]: data=%h dest=%0d want %h/%0d", i, got_data[i], got_dest[i], 8'h40 + 8'(i), sent_dest[i]);
      end
    end
  endtask

  task automatic test_scatter();
    do_reset();
    bus.mode      = 1'b1;
    bus.out_ready = 8'hFF;
    push_words(10, 8'h00, 1'b1, 3'd0);
    wait_got(10, 100);
    total++; if (!push_ok || !wait_ok) begin bad++; $display("FAIL rr_done: pushed=%b got=%0d want 10", push_ok, got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'(i) || got_dest[i] !== 3'(i % 8)) begin
        bad++; $display("FAIL rr_word[%0d]: data=%h dest=%0d want %h/%0d", i, got_data[i], got_dest[i], 8'(i), i % 8);
      end
    end
    clear_mon();
    push_words(1, 8'h77, 1'b1, 3'd0);
    wait_got(1, 20);
    total++; if (got_dest.size() != 1 || got_dest[0] !== 3'd2) begin
      bad++; $display("FAIL rr_ptr_end: transfers=%0d dest=%0d want 1/2", got_dest.size(), got_dest.size() > 0 ? int'(got_dest[0]) : -1);
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    do_reset();
    bus.mode      = 1'b0;
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_data = 8'h30 + 8'(accepted);
      bus.in_dest = 3'(accepted);
      #1;
      if (bus.in_ready) accepted++;
      cycle();
    end
    bus.in_data = 8'h35;
    bus.in_dest = 3'd5;
    #1;
    total++; if (accepted != 5) begin bad++; $display("FAIL bp_accepted: got %0d want 5", accepted); end
    total++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL bp_full: in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy); end
    total++; if (bus.out_valid !== 8'h01) begin bad++; $display("FAIL bp_held: out_valid=%b want 00000001", bus.out_valid); end
    bus.out_ready = 8'hFF;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_xfer_cycle_in_ready: got %b want 0", bus.in_ready); end
    cycle();
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 8'h00) begin bad++; $display("FAIL bp_pop_cycle: in_ready=%b out_valid=%b want 0/0", bus.in_ready, bus.out_valid); end
    cycle();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop_in_ready: got %b want 1", bus.in_ready); end
    cycle();
    bus.in_valid = 1'b0;
    wait_got(6, 100);
    total++; if (!wait_ok) begin bad++; $display("FAIL bp_drain: got %0d want 6", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 8'h30 + 8'(i) || got_dest[i] !== 3'(i)) begin
        bad++; $display("FAIL bp_order[%0d]: data=%h dest=%0d want %h/%0d", i, got_data[i], got_dest[i], 8'h30 + 8'(i), i);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.mode      = 1'b0;
    bus.out_ready = 8'hF7;
    push_words(1, 8'hC0, 1'b0, 3'd3);
    push_words(1, 8'hC1, 1'b0, 3'd6);
    repeat (60) cycle();
`ifdef DEMUX_TIMEOUT_EN
    total++; if (valid_cycles[3] != 15) begin bad++; $display("FAIL to_wait_cycles: got %0d want 15", valid_cycles[3]); end
    total++; if (err_pulses != 1) begin bad++; $display("FAIL to_err_pulses: got %0d want 1", err_pulses); end
    total++; if (bus.drop_cnt !== 8'd1) begin bad++; $display("FAIL to_drop_cnt: got %0d want 1", bus.drop_cnt); end
    total++; if (got_data.size() != 1 || got_data[0] !== 8'hC1 || got_dest[0] !== 3'd6) begin
      bad++; $display("FAIL to_next_word: transfers=%0d want 1 word c1 on dest 6", got_data.size());
    end
`else
    total++; if (valid_cycles[3] < 55 || bus.out_valid !== 8'h08) begin
      bad++; $display("FAIL hold_forever: cycles=%0d out_valid=%b want >=55/00001000", valid_cycles[3], bus.out_valid);
    end
    total++; if (err_pulses != 0 || bus.drop_cnt !== 8'h00) begin bad++; $display("FAIL no_timeout: pulses=%0d drop_cnt=%0d want 0/0", err_pulses, bus.drop_cnt); end
    bus.out_ready = 8'hFF;
    wait_got(2, 20);
    total++; if (!wait_ok || got_data[0] !== 8'hC0 || got_data[1] !== 8'hC1 || got_dest[0] !== 3'd3 || got_dest[1] !== 3'd6) begin
      bad++; $display("FAIL hold_release: transfers=%0d want c0@3 then c1@6", got_data.size());
    end
`endif
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    bus.mode      = 1'b0;
    bus.out_ready = 8'h00;
    push_words(4, 8'h50, 1'b1, 3'd0);
    total++; if (bus.busy !== 1'b1 || bus.out_valid === 8'h00) begin bad++; $display("FAIL rms_pre: busy=%b out_valid=%b want 1/nonzero", bus.busy, bus.out_valid); end
    rst = 1'b1;
    cycle();
    total++; if (bus.out_valid !== 8'h00 || bus.busy !== 1'b0) begin bad++; $display("FAIL rms_cleared: out_valid=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
    total++; if (bus.drop_cnt !== 8'h00 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rms_no_drop: drop_cnt=%0d err=%b want 0/0", bus.drop_cnt, bus.timeout_err); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rms_in_ready_rst: got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rms_in_ready_after: got %b want 1", bus.in_ready); end
    bus.out_ready = 8'hFF;
    clear_mon();
    repeat (10) cycle();
    total++; if (got_data.size() != 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rms_flushed: transfers=%0d busy=%b want 0/0", got_data.size(), bus.busy); end
  endtask

  task automatic test_push_pop();
    do_reset();
    bus.mode      = 1'b0;
    bus.out_ready = 8'h00;
    push_words(3, 8'h60, 1'b1, 3'd0);
    bus.out_ready = 8'hFF;
    cycle();
    // Held word gone, two queued: next cycle pops and pushes together.
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 8'h00) begin bad++; $display("FAIL pp_setup: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    push_words(5, 8'h63, 1'b1, 3'd0);
    wait_got(8, 100);
    total++; if (!push_ok || !wait_ok) begin bad++; $display("FAIL pp_done: pushed=%b got=%0d want 8", push_ok, got_data.size()); end
    for (int i = 0; i < got_data.size() && i < sent_dest.size(); i++) begin
      total++;
      if (got_data[i] !== 8'h60 + 8'(i) || got_dest[i] !== sent_dest[i]) begin
        bad++; $display("FAIL pp_order[%0d]: data=%h dest=%0d want %h/%0d", i, got_data[i], got_dest[i], 8'h60 + 8'(i), sent_dest[i]);
      end
    end
    repeat (4) cycle();
    total++; if (got_data.size() != 8 || bus.busy !== 1'b0) begin bad++; $display("FAIL pp_no_dup: transfers=%0d busy=%b want 8/0", got_data.size(), bus.busy); end
  endtask

  // Randomized traffic against a queue model: words leave in arrival order; destination
  // is the word's address or a running round-robin count advanced per word leaving.
  task automatic test_random();
    logic [7:0] q_data[$];
    logic [2:0] q_dest[$];
    int         rr;
    int         exp_idx;
    bit         drain;
`ifdef DEMUX_TIMEOUT_EN
    int         waitc;
    int         exp_drop;
    bit         exp_err;
    waitc    = 0;
    exp_drop = 0;
    exp_err  = 1'b0;
`endif
    do_reset();
    rr = 0;
    for (int ph = 0; ph < 2; ph++) begin
      bus.mode = ph[0];
      drain = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if (c == 300) drain = 1'b1;
        if (!drain) begin
          bus.in_valid  = 1'($urandom_range(0, 1));
          bus.in_data   = 8'($urandom);
          bus.in_dest   = 3'($urandom);
          bus.out_ready = ($urandom_range(0, 3) != 0) ? 8'($urandom) : 8'h00;
        end else begin
          bus.in_valid  = 1'b0;
          bus.out_ready = 8'hFF;
        end
        #1;
`ifdef DEMUX_TIMEOUT_EN
        total++; if (bus.timeout_err !== exp_err || bus.drop_cnt !== 8'(exp_drop)) begin
          bad++; $display("FAIL rnd_drop: err=%b cnt=%0d want %b/%0d", bus.timeout_err, bus.drop_cnt, exp_err, exp_drop);
        end
        exp_err = 1'b0;
`else
        total++; if (bus.timeout_err !== 1'b0 || bus.drop_cnt !== 8'h00) begin
          bad++; $display("FAIL rnd_no_drop: err=%b cnt=%0d want 0/0", bus.timeout_err, bus.drop_cnt);
        end
`endif
        if (bus.out_valid != 8'h00) begin
          total++;
          if (q_data.size() == 0) begin
            bad++; $display("FAIL rnd_spurious: out_valid=%b with no word pending", bus.out_valid);
          end else begin
            exp_idx = bus.mode ? rr : int'(q_dest[0]);
            if (bus.out_valid !== (8'h01 << exp_idx) || bus.out_data !== q_data[0]) begin
              bad++; $display("FAIL rnd_word: out_valid=%b data=%h want dest %0d data %h", bus.out_valid, bus.out_data, exp_idx, q_data[0]);
            end
            if (bus.out_ready[bus.sel]) begin
              void'(q_data.pop_front());
              void'(q_dest.pop_front());
              if (bus.mode) rr = (rr + 1) % 8;
`ifdef DEMUX_TIMEOUT_EN
              waitc = 0;
            end else begin
              waitc++;
              if (waitc == int'(TIMEOUT)) begin
                void'(q_data.pop_front());
                void'(q_dest.pop_front());
                if (bus.mode) rr = (rr + 1) % 8;
                waitc   = 0;
                exp_err = 1'b1;
                if (exp_drop < 255) exp_drop++;
              end
`endif
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          q_data.push_back(bus.in_data);
          q_dest.push_back(bus.in_dest);
        end
`ifdef DEMUX_TIMEOUT_EN
        if (drain && q_data.size() == 0 && !bus.busy && !exp_err) break;
`else
        if (drain && q_data.size() == 0 && !bus.busy) break;
`endif
        cycle();
      end
      total++; if (q_data.size() != 0 || bus.busy !== 1'b0) begin
        bad++; $display("FAIL rnd_drain_ph%0d: pending=%0d busy=%b want 0/0", ph, q_data.size(), bus.busy);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 8'h00;
    clear_mon();
    test_reset();
    test_addressed();
    test_scatter();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    test_push_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Sequencer in front of the 1-to-8 demultiplexer datapath. Buffers incoming words in a small FIFO and selects one of 8 destinations per word. Destination comes either from the word's own address (addressed mode) or from an internal round-robin pointer (scatter mode). Presents each word on exactly one destination with a valid/ready handshake, and drops words stuck on an unresponsive destination.

Parameters:
DW, 8, data word width in bits
DEPTH, 4, input FIFO entries; power of 2, minimum 2
TIMEOUT, 15, maximum cycles a word waits in SEND before it is dropped; range 1..255

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream word valid
in_ready  output  1  FIFO can accept a word
in_data  input  DW  upstream word
in_dest  input  3  destination index, used in addressed mode
mode  input  1  0 = addressed (use in_dest), 1 = round-robin scatter
out_valid  output  8  one-hot valid; bit k = destination k
out_data  output  DW  word being dispatched, shared by all destinations
out_ready  input  8  per-destination ready
sel  output  3  binary index of current destination ({s2,s1,s0} of the demux)
busy  output  1  high in SEND, or when FIFO is non-empty
timeout_err  output  1  one-cycle pulse when a word is dropped
drop_cnt  output  8  count of dropped words, saturates at 255

Behaviour:
- Reset: synchronous, active-high.
  - FIFO count = 0; read/write pointers = 0; rr_ptr = 0; state = IDLE.
  - in_ready = 0 while rst is high.
  - out_valid = 0, out_data = 0, sel = 0, busy = 0, timeout_err = 0, drop_cnt = 0.
  - Reset mid-SEND discards the held word and all FIFO contents; no drop is counted.
- FIFO:
  - in_ready = (count < DEPTH) when rst is low.
  - Push on in_valid & in_ready; each entry stores {in_dest, in_data}.
  - Pop only by the FSM in IDLE.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: in_ready = 0, even in a cycle that pops (no combinational path from pop to in_ready).
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count > 0, pop the head into the hold registers.
    - Set sel = mode ? rr_ptr : head_dest (mode is sampled at pop time).
    - Clear the wait counter; go to SEND.
    - Otherwise stay in IDLE.
  - SEND: out_valid = one-hot(sel), i.e. bit sel = 1, all other bits 0; out_data = held word.
    - If out_ready[sel] = 1: transfer completes this cycle. If mode was 1 at pop, rr_ptr <= rr_ptr + 1 (7 wraps to 0). Go to IDLE.
    - Else increment the wait counter. When the counter reaches TIMEOUT with out_ready[sel] still low: drop the word, pulse timeout_err for 1 cycle, drop_cnt <= min(drop_cnt + 1, 255), go to IDLE. rr_ptr still advances in scatter mode.
    - out_ready bits other than sel are ignored.
- out_valid = 0 in IDLE. At most one out_valid bit is ever high.
- out_data and sel hold their last value in IDLE.
- Latency: word accepted at edge N -> IDLE pops at edge N+1 -> out_valid high during cycle N+2.
  - Back-to-back words: at most one word every 2 cycles (SEND -> IDLE -> SEND).
- busy = (state == SEND) | (count != 0).

Optional Feature:
DEMUX_TIMEOUT_EN.
- Defined: wait counter, timeout drop, timeout_err and drop_cnt behave as described above.
- Undefined: SEND waits indefinitely for out_ready[sel]; no wait counter is built; timeout_err is tied 0 and drop_cnt is tied 0. TIMEOUT is unused.

Test Plan:
1. Reset, then mode=0; push in_data=0xA5, in_dest=5 with out_ready=8'hFF -> out_valid=8'b0010_0000, sel=5, out_data=0xA5 exactly 2 cycles after acceptance, for 1 cycle.
2. mode=1; push 10 words 0x00..0x09 with out_ready=8'hFF -> destinations 0,1,…,7,0,1 in order; in_dest ignored; rr_ptr=2 at end.
3. out_ready=0; push 5 words with DEPTH=4 -> 1 word held in SEND plus 4 in FIFO; in_ready=0; the 6th in_valid is not accepted until a pop.
4. DEMUX_TIMEOUT_EN defined, TIMEOUT=15, in_dest=3, out_ready[3]=0 -> timeout_err pulses once after 15 SEND wait cycles; drop_cnt=1; next FIFO word then dispatched.
5. Assert rst for 1 cycle while in SEND with 3 words queued -> next cycle: out_valid=0, busy=0, count=0, drop_cnt unchanged, in_ready=1 after rst falls.
6. Push and pop in the same cycle at count=2 -> count stays 2; words are emitted in FIFO order with no loss or duplication.
